// File: rtl/tff_rx_pkg.sv
// Shared types and default sizing for the toggle-flop event receiver.
package tff_rx_pkg;

  localparam int TFF_RX_CNT_W      = 8;
  localparam int TFF_RX_PEND_DEPTH = 4;

  typedef enum logic [1:0] {
    Q_EMPTY  = 2'd0,
    Q_ACTIVE = 2'd1,
    Q_FULL   = 2'd2
  } q_state_e;

  // Queue state is not stored separately; it is always a view of the fill level.
  function automatic q_state_e level_to_state(input int unsigned level,
                                              input int unsigned depth);
    q_state_e st;
    if (level == 32'd0) begin
      st = Q_EMPTY;
    end else if (level >= depth) begin
      st = Q_FULL;
    end else begin
      st = Q_ACTIVE;
    end
    return st;
  endfunction

endpackage

// File: rtl/toggle_sync.sv
// Resynchronises the remote toggle line and turns each level change into a one-cycle pulse.
// Optional two-flop synchroniser selected by TFF_TOGGLE_RX_SYNC_EN.
module toggle_sync (
  input  logic clk,
  input  logic rst,
  input  logic t_in,
  output logic edge_pulse
);

  logic line_s;
  logic prev_q;
  logic tgl_s;
  logic edge_q;

`ifdef TFF_TOGGLE_RX_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  // Synchroniser flops deliberately ignore rst so a held input level settles during reset.
  always_ff @(posedge clk) begin
    sync1_q <= t_in;
    sync2_q <= sync1_q;
  end

  assign line_s = sync2_q;
`else
  assign line_s = t_in;
`endif

  always_ff @(posedge clk) begin
    prev_q <= line_s;
  end

  assign tgl_s = line_s ^ prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_q <= 1'b0;
    end else begin
      edge_q <= tgl_s;
    end
  end

  assign edge_pulse = edge_q;

endmodule

// File: rtl/tff_toggle_rx.sv
// Toggle-flop receiver: edge detection, pending-event queue with valid/ready, event counter, sticky overflow.
// Synchroniser enabled by defining TFF_TOGGLE_RX_SYNC_EN.
module tff_toggle_rx
  import tff_rx_pkg::*;
#(
  parameter int CNT_W      = TFF_RX_CNT_W,
  parameter int PEND_DEPTH = TFF_RX_PEND_DEPTH,
  localparam int PEND_W    = $clog2(PEND_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              t_in,
  input  logic              clr_cnt,
  output logic              edge_pulse,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [PEND_W-1:0] pend_level,
  output logic [CNT_W-1:0]  evt_count,
  output logic              overflow
);

  logic              edge_s;
  logic              pop_s;
  logic              drop_s;
  q_state_e          state_s;

  logic [PEND_W-1:0] pend_q, pend_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  toggle_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .t_in       (t_in),
    .edge_pulse (edge_s)
  );

  assign state_s = level_to_state(32'(pend_q), 32'(PEND_DEPTH));
  assign pop_s   = valid_q & evt_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= {PEND_W{1'b0}};
      valid_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      ovf_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Queue transitions; a pulse arriving in FULL is dropped only when nothing leaves that cycle.
  always_comb begin
    pend_d = pend_q;
    drop_s = 1'b0;
    case (state_s)
      Q_EMPTY: begin
        if (edge_s) begin
          pend_d = pend_q + PEND_W'(1);
        end else begin
          pend_d = pend_q;
        end
      end
      Q_ACTIVE: begin
        if (edge_s && !pop_s) begin
          pend_d = pend_q + PEND_W'(1);
        end else if (!edge_s && pop_s) begin
          pend_d = pend_q - PEND_W'(1);
        end else begin
          pend_d = pend_q;
        end
      end
      Q_FULL: begin
        if (edge_s && !pop_s) begin
          drop_s = 1'b1;
          pend_d = pend_q;
        end else if (!edge_s && pop_s) begin
          pend_d = pend_q - PEND_W'(1);
        end else begin
          pend_d = pend_q;
        end
      end
      default: begin
        pend_d = {PEND_W{1'b0}};
        drop_s = 1'b0;
      end
    endcase
    valid_d = (pend_d != {PEND_W{1'b0}});
  end

  // Counter counts every pulse, dropped or not; a simultaneous drop wins over clr_cnt for overflow.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_cnt) begin
      if (edge_s) begin
        cnt_d = CNT_W'(1);
      end else begin
        cnt_d = {CNT_W{1'b0}};
      end
    end else if (edge_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (clr_cnt) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  assign edge_pulse = edge_s;
  assign evt_valid  = valid_q;
  assign pend_level = pend_q;
  assign evt_count  = cnt_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_tff_toggle_rx.sv
// Directed self-checking bench for tff_toggle_rx with a pulse-timing scoreboard.
module tb_tff_toggle_rx;

`ifdef TFF_TOGGLE_RX_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       t_in;
  logic       clr_cnt;
  logic       evt_ready;

  logic       edge_pulse, evt_valid, overflow;
  logic [2:0] pend_level;
  logic [7:0] evt_count;

  logic       edge_c4, valid_c4, ovf_c4;
  logic [2:0] pend_c4;
  logic [3:0] count_c4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_cycles = 0;
  int pops = 0;
  int sb[$];

  tff_toggle_rx dut (
    .clk(clk), .rst(rst), .t_in(t_in), .clr_cnt(clr_cnt),
    .edge_pulse(edge_pulse), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .pend_level(pend_level), .evt_count(evt_count), .overflow(overflow)
  );

  tff_toggle_rx #(.CNT_W(4)) dut_c4 (
    .clk(clk), .rst(rst), .t_in(t_in), .clr_cnt(clr_cnt),
    .edge_pulse(edge_c4), .evt_valid(valid_c4), .evt_ready(evt_ready),
    .pend_level(pend_c4), .evt_count(count_c4), .overflow(ovf_c4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Each pulse must arrive exactly at the cycle recorded when its toggle was driven.
  always @(negedge clk) begin
    if (edge_pulse === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        assert (1'b0) else begin
          errors++;
          $error("FAIL spurious_pulse: observed pulse at cycle %0d expected none", cyc);
        end
      end else begin
        int exp_cyc;
        exp_cyc = sb.pop_front();
        check("pulse_cycle", cyc, exp_cyc);
      end
    end
    if (!rst && evt_valid === 1'b1) valid_cycles++;
    if (!rst && evt_valid === 1'b1 && evt_ready === 1'b1) pops++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic toggle();
    t_in = ~t_in;
    sb.push_back(cyc + LAT);
  endtask

  task automatic toggle_n(input int n);
    for (int i = 0; i < n; i++) begin
      toggle();
      repeat (4) tick();
    end
  endtask

  task automatic wait_pulse(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (edge_pulse === 1'b1) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    rst = 1'b1; t_in = 1'b1; clr_cnt = 1'b0; evt_ready = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    repeat (3) tick();
    // Reset state: held level never counts
    check("rst_count", 32'(evt_count), 32'd0);
    check("rst_pend", 32'(pend_level), 32'd0);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_edge", 32'(edge_c4), 32'd0);

    // Two toggles consumed immediately
    evt_ready = 1'b1;
    valid_cycles = 0;
    toggle_n(2);
    repeat (2) tick();
    check("t2_count", 32'(evt_count), 32'd2);
    check("t2_valid_cycles", 32'(valid_cycles), 32'd2);
    check("t2_pend", 32'(pend_level), 32'd0);
    check("t2_sb_empty", 32'(sb.size()), 32'd0);

    // Fill, overflow, drain
    evt_ready = 1'b0;
    clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
    check("t3_clr", 32'(evt_count), 32'd0);
    toggle_n(4);
    check("t3_full_pend", 32'(pend_level), 32'd4);
    check("t3_full_noovf", 32'(overflow), 32'd0);
    toggle(); repeat (5) tick();
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_pend", 32'(pend_level), 32'd4);
    check("t3_count", 32'(evt_count), 32'd5);
    check("t3_count_c4", 32'(count_c4), 32'd5);
    pops = 0;
    evt_ready = 1'b1;
    repeat (6) tick();
    check("t3_pops", 32'(pops), 32'd4);
    check("t3_valid_after", 32'(evt_valid), 32'd0);
    check("t3_ovf_sticky", 32'(overflow), 32'd1);

    // Pop coincides with pulse while FULL
    evt_ready = 1'b0;
    clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
    check("t4_ovf_clr", 32'(overflow), 32'd0);
    toggle_n(4);
    check("t4_full", 32'(pend_level), 32'd4);
    toggle();
    wait_pulse("t4_pulse_seen");
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("t4_pend", 32'(pend_level), 32'd4);
    check("t4_ovf", 32'(overflow), 32'd0);
    check("t4_valid", 32'(evt_valid), 32'd1);

    // Reset mid-operation with pend_level=3 and overflow set
    toggle(); repeat (5) tick();
    check("t6_drop_ovf", 32'(overflow), 32'd1);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    check("t6_pend3", 32'(pend_level), 32'd3);
    rst = 1'b1; tick();
    check("t6_rst_pend", 32'(pend_level), 32'd0);
    check("t6_rst_valid", 32'(evt_valid), 32'd0);
    check("t6_rst_ovf", 32'(overflow), 32'd0);
    check("t6_rst_count", 32'(evt_count), 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (6) tick();
    check("t6_sb_empty", 32'(sb.size()), 32'd0);
    check("t6_pend_after", 32'(pend_level), 32'd0);
    check("t6_valid_c4", 32'(valid_c4), 32'd0);

    // Counter wrap on 4-bit instance, then clr_cnt coinciding with a pulse
    evt_ready = 1'b1;
    toggle_n(17);
    repeat (2) tick();
    check("t5_wrap_c4", 32'(count_c4), 32'd1);
    check("t5_count8", 32'(evt_count), 32'd17);
    check("t5_pend_c4", 32'(pend_c4), 32'd0);
    toggle();
    wait_pulse("t5_pulse_seen");
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("t5_clr_edge", 32'(evt_count), 32'd1);
    check("t5_clr_edge_c4", 32'(count_c4), 32'd1);
    check("t5_ovf", 32'(overflow), 32'd0);
    check("t5_ovf_c4", 32'(ovf_c4), 32'd0);
    repeat (4) tick();
    check("t5_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
